// File: rtl/scratchpad_mp_if.sv
`default_nettype none
// ============================================================================
// Module   : scratchpad_mp_if
// Brief    : Bus bundle for the multi-read-port scratchpad (control, reads, write).
// Revision : 1.0 - initial release
// ============================================================================
interface scratchpad_mp_if #(
  parameter int WIDTH       = 8,
  parameter int PARALLELISM = 1,
  parameter int HEIGHT      = 128,
  parameter int N_READ      = 2
);
  localparam int DW = PARALLELISM * WIDTH;
  localparam int AW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  logic                   CS;
  logic                   clear_req;
  logic                   busy;
  logic [N_READ*AW-1:0]   read_addr;
  logic [N_READ-1:0]      read_en;
  logic [N_READ*DW-1:0]   qout;
  logic [AW-1:0]          write_addr;
  logic                   write_en;
  logic [PARALLELISM-1:0] write_mask;
  logic [DW-1:0]          din;

  modport master (
    output CS, clear_req, read_addr, read_en, write_addr, write_en, write_mask, din,
    input  busy, qout
  );

  modport slave (
    input  CS, clear_req, read_addr, read_en, write_addr, write_en, write_mask, din,
    output busy, qout
  );
endinterface
`default_nettype wire

// File: rtl/scratchpad_mp.sv
`default_nettype none
// ============================================================================
// Module   : scratchpad_mp
// Brief    : N-read/1-write scratchpad with lane masks, optional bypass, hold-last
//            read outputs and a hardware clear engine.
// Revision : 1.0 - initial release
// ============================================================================
module scratchpad_mp #(
  parameter int WIDTH          = 8,
  parameter int PARALLELISM    = 1,
  parameter int HEIGHT         = 128,
  parameter int N_READ         = 2,
  parameter int BYPASS         = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  wire logic       clk,
  input  wire logic       rst,
  scratchpad_mp_if.slave  bus
);
  localparam int DW = PARALLELISM * WIDTH;
  localparam int AW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [AW:0]   c_HEIGHT = (AW+1)'(HEIGHT);
  localparam logic [AW-1:0] c_LAST   = AW'(HEIGHT - 1);

  localparam logic [0:0] S_READY = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  logic [0:0]          r_state;
  logic [0:0]          w_next;
  logic                w_busy;
  logic [AW-1:0]       r_clr_cnt;
  logic [DW-1:0]       r_mem [HEIGHT];
  logic                w_wr_valid;
  logic                w_wr;
  logic                w_enter_clear;
  logic [N_READ*DW-1:0] w_qout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_READY: if (bus.clear_req)        w_next = S_CLEAR;
      S_CLEAR: if (r_clr_cnt == c_LAST)  w_next = S_READY;
      default:                           w_next = S_READY;
    endcase
  end

  always_comb begin
    w_busy = (r_state == S_CLEAR);
  end

  assign bus.busy      = w_busy;
  assign w_enter_clear = (r_state == S_READY) && bus.clear_req;
  assign w_wr_valid    = ({1'b0, bus.write_addr} < c_HEIGHT);
  assign w_wr          = !w_busy && bus.CS && bus.write_en && w_wr_valid;

  // Counter idles at 0 outside CLEAR so every clear (and reset) starts at word 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                r_clr_cnt <= '0;
    else if (w_busy && r_clr_cnt != c_LAST) r_clr_cnt <= r_clr_cnt + AW'(1);
    else                                    r_clr_cnt <= '0;
  end

  always_ff @(posedge clk) begin
    if (w_busy) begin
      r_mem[r_clr_cnt] <= '0;
    end else if (w_wr) begin
      for (int k = 0; k < PARALLELISM; k++) begin
        if (bus.write_mask[k]) r_mem[bus.write_addr][k*WIDTH +: WIDTH] <= bus.din[k*WIDTH +: WIDTH];
      end
    end
  end

  for (genvar i = 0; i < N_READ; i++) begin : g_rd
    logic [AW-1:0] w_raddr;
    logic          w_rvalid;
    logic [DW-1:0] w_mem_q;
    logic [DW-1:0] w_rd;
    logic [DW-1:0] r_hold;

    assign w_raddr  = bus.read_addr[i*AW +: AW];
    assign w_rvalid = ({1'b0, w_raddr} < c_HEIGHT);
    assign w_mem_q  = (bus.CS && w_rvalid) ? r_mem[w_raddr] : '0;

    if (BYPASS != 0) begin : g_byp
      logic w_hit;
      assign w_hit = bus.CS && bus.write_en && w_wr_valid && (bus.write_addr == w_raddr);
      always_comb begin
        w_rd = w_mem_q;
        if (w_hit) begin
          for (int k = 0; k < PARALLELISM; k++) begin
            if (bus.write_mask[k]) w_rd[k*WIDTH +: WIDTH] = bus.din[k*WIDTH +: WIDTH];
          end
        end
      end
    end else begin : g_nobyp
      assign w_rd = w_mem_q;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst)                             r_hold <= '0;
      else if (w_enter_clear)              r_hold <= '0;
      else if (!w_busy && bus.read_en[i])  r_hold <= w_rd;
    end

    assign w_qout[i*DW +: DW] = (rst || w_busy) ? '0 : (bus.read_en[i] ? w_rd : r_hold);
  end

  assign bus.qout = w_qout;
endmodule
`default_nettype wire
